// File: rtl/mem_port_arbiter.sv
// Arbitrates a load port and a store-buffer head onto a single registered memory port.
// Optional store anti-starvation is enabled by defining MEM_ARB_ANTI_STARVE_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_gnt,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        st_full,
  output logic        st_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusyLd, StBusySt} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        ld_gnt_q, ld_gnt_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        st_ack_q, st_ack_d;

  logic force_st;
  logic go_st, go_ld;

  // Decision is only taken in IDLE; requester inputs are ignored while busy.
  assign go_st = (state_q == StIdle) && st_req && (st_full || force_st || !ld_req);
  assign go_ld = (state_q == StIdle) && ld_req && !go_st;

`ifdef MEM_ARB_ANTI_STARVE_EN
  logic [3:0] streak_q, streak_d;

  assign force_st = st_req && (streak_q >= 4'(STARVE_LIMIT));

  always_comb begin
    streak_d = streak_q;
    if (go_st) begin
      streak_d = '0;
    end else if (go_ld) begin
      if (!st_req) begin
        streak_d = '0;
      end else if (streak_q != 4'hF) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_st = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_data_d   = ld_data_q;
    ld_gnt_d    = 1'b0;
    ld_valid_d  = 1'b0;
    st_ack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_st) begin
          state_d     = StBusySt;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = st_addr;
          mem_wdata_d = st_data;
        end else if (go_ld) begin
          state_d    = StBusyLd;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = ld_addr;
          ld_gnt_d   = 1'b1;
        end
      end
      StBusyLd: begin
        if (mem_done) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          ld_data_d  = mem_rdata;
          ld_valid_d = 1'b1;
        end
      end
      StBusySt: begin
        if (mem_done) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          st_ack_d  = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_gnt_q    <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      st_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_gnt_q    <= ld_gnt_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      st_ack_q    <= st_ack_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_gnt    = ld_gnt_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign st_ack    = st_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus a sustained-contention sequence.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_gnt;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_full;
  logic        st_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_gnt   (ld_gnt),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_full  (st_full),
    .st_ack   (st_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done)
  );

  typedef struct {
    logic        rst;
    logic        ldr;
    logic [31:0] lda;
    logic        str;
    logic [31:0] sta;
    logic [31:0] std;
    logic        stf;
    logic        done;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_gnt;
    logic        e_valid;
    logic [31:0] e_ldata;
    logic        e_ack;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic ldr, logic [31:0] lda, logic str,
                              logic [31:0] sta, logic [31:0] std, logic stf, logic done,
                              logic [31:0] rdata, logic e_req, logic e_we,
                              logic [31:0] e_addr, logic [31:0] e_wdata, logic e_gnt,
                              logic e_valid, logic [31:0] e_ldata, logic e_ack);
    vec_t v;
    v.rst = rst; v.ldr = ldr; v.lda = lda; v.str = str; v.sta = sta; v.std = std;
    v.stf = stf; v.done = done; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_gnt = e_gnt; v.e_valid = e_valid; v.e_ldata = e_ldata; v.e_ack = e_ack;
    return v;
  endfunction

  task automatic check(string name, logic [100:0] got, logic [100:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    logic [100:0] got_v, exp_v;
    int           n_acc, n_ack;
    logic         prev_req;
    logic         ops[10];
    int           exp_ack;

    reset = 1'b1; ld_req = 1'b0; ld_addr = '0; st_req = 1'b0; st_addr = '0;
    st_data = '0; st_full = 1'b0; mem_rdata = '0; mem_done = 1'b0;

    // Reset values
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0));
    // Load with 2-cycle memory, then a stray mem_done in IDLE
    vq.push_back(mk(0,1,'h100,0,0,0,0,0,0,          1,0,'h100,0,1,0,0,0));
    vq.push_back(mk(0,0,'h100,0,0,0,0,0,0,          1,0,'h100,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1,'hDEADBEEF,     0,0,'h100,0,0,1,'hDEADBEEF,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1,'h55,           0,0,'h100,0,0,0,'hDEADBEEF,0));
    // Plain store
    vq.push_back(mk(0,0,0,1,'h200,'h12345678,0,0,0, 1,1,'h200,'h12345678,0,0,'hDEADBEEF,0));
    vq.push_back(mk(0,0,0,1,'h200,'h12345678,0,1,'h77,
                    0,1,'h200,'h12345678,0,0,'hDEADBEEF,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,             0,1,'h200,'h12345678,0,0,'hDEADBEEF,0));
    // Full store buffer beats a pending load
    vq.push_back(mk(0,1,'h300,1,'h400,'hA5A5A5A5,1,0,0,
                    1,1,'h400,'hA5A5A5A5,0,0,'hDEADBEEF,0));
    vq.push_back(mk(0,1,'h300,1,'h400,'hA5A5A5A5,1,1,0,
                    0,1,'h400,'hA5A5A5A5,0,0,'hDEADBEEF,1));
    vq.push_back(mk(0,1,'h300,0,0,0,0,0,0,          1,0,'h300,'hA5A5A5A5,1,0,'hDEADBEEF,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1,'hCAFEF00D,     0,0,'h300,'hA5A5A5A5,0,1,'hCAFEF00D,0));
    // Non-full store loses to load, then goes next
    vq.push_back(mk(0,1,'h500,1,'h600,'h11,0,0,0,   1,0,'h500,'hA5A5A5A5,1,0,'hCAFEF00D,0));
    vq.push_back(mk(0,0,0,1,'h600,'h11,0,1,'h22,    0,0,'h500,'hA5A5A5A5,0,1,'h22,0));
    vq.push_back(mk(0,0,0,1,'h600,'h11,0,0,0,       1,1,'h600,'h11,0,0,'h22,0));
    vq.push_back(mk(0,0,0,1,'h600,'h11,0,0,0,       1,1,'h600,'h11,0,0,'h22,0));
    // Reset during BUSY_ST, then a late mem_done
    vq.push_back(mk(1,0,0,1,'h600,'h11,0,0,0,       0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1,'h99,           0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; ld_req = vq[i].ldr; ld_addr = vq[i].lda; st_req = vq[i].str;
      st_addr = vq[i].sta; st_data = vq[i].std; st_full = vq[i].stf;
      mem_done = vq[i].done; mem_rdata = vq[i].rdata;
      @(posedge clk);
      #1;
      got_v = {mem_req, mem_we, mem_addr, mem_wdata, ld_gnt, ld_valid, ld_data, st_ack};
      exp_v = {vq[i].e_req, vq[i].e_we, vq[i].e_addr, vq[i].e_wdata, vq[i].e_gnt,
               vq[i].e_valid, vq[i].e_ldata, vq[i].e_ack};
      check($sformatf("vec%0d", i), got_v, exp_v);
    end

    // Sustained contention: load and non-full store requested continuously
    reset = 1'b1; ld_req = 1'b0; st_req = 1'b0; st_full = 1'b0; mem_done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; ld_req = 1'b1; ld_addr = 'h700; st_req = 1'b1;
    st_addr = 'h800; st_data = 'h5A5A0000;
    n_acc = 0; n_ack = 0; prev_req = 1'b0;
    for (int cyc = 0; cyc < 300 && n_acc < 10; cyc++) begin
      @(posedge clk);
      #1;
      if (st_ack) n_ack++;
      if (mem_req && !prev_req) begin
        ops[n_acc] = mem_we;
        check($sformatf("gnt_at_start%0d", n_acc), {100'd0, ld_gnt}, {100'd0, !mem_we});
        n_acc++;
      end
      mem_done = mem_req && !mem_done;
      prev_req = mem_req;
    end
    mem_done = 1'b0;
    ld_req = 1'b0;
    st_req = 1'b0;
    check_int("contention_access_count", n_acc, 10);
    for (int i = 0; i < n_acc; i++) begin
`ifdef MEM_ARB_ANTI_STARVE_EN
      check($sformatf("contention_op%0d", i), {100'd0, ops[i]}, {100'd0, (i % 5) == 4});
`else
      check($sformatf("contention_op%0d", i), {100'd0, ops[i]}, 101'd0);
`endif
    end
`ifdef MEM_ARB_ANTI_STARVE_EN
    exp_ack = 1;
`else
    exp_ack = 0;
`endif
    check_int("contention_st_acks", n_ack, exp_ack);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
